// File: rtl/sram_controller.sv
// MEM-stage load/store responder for a 16-bit asynchronous SRAM.
// Each 32-bit request becomes two timed half-accesses (low half, then high
// half). ready is held low while an access is in flight so the pipeline
// freezes; load data is returned together with a one-cycle ready pulse.
// Optional feature: define SRAM_RANGE_CHECK_EN to reject out-of-range
// addresses (skip the SRAM, pulse err, loads return 0).
module sram_controller #(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 4,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        ALU_Res,
  input  logic [31:0]        ST_val,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic               err,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [15:0]        SRAM_DQ,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N
);

  localparam int         WW   = SRAM_AW - 1;           // word index width
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);   // last phase cycle

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  typedef struct packed {
    logic          store;
    logic [WW-1:0] word;
    logic [31:0]   data;
  } req_t;

  state_t        state, nxt;
  logic [3:0]    cnt;
  logic          last;
  req_t          req_q;
  logic          req;
  logic [WW-1:0] word_d;
  logic          range_bad;
  logic          dq_oe;
  logic [15:0]   dq_out;

  assign req    = MEM_R_EN | MEM_W_EN;
  // Byte offset from the base, >>2, truncated: each word spans two locations.
  assign word_d = WW'((ALU_Res - 32'(ADDR_BASE)) >> 2);
  assign last   = (cnt == LAST);

`ifdef SRAM_RANGE_CHECK_EN
  logic [31:0] offset;
  logic        err_q;
  assign offset    = ALU_Res - 32'(ADDR_BASE);
  assign range_bad = (ALU_Res < 32'(ADDR_BASE)) || ((offset >> (SRAM_AW + 1)) != 32'd0);
  assign err       = err_q;

  // err is registered off the IDLE->DONE decision, so it is high for DONE only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= (state == IDLE) && req && range_bad;
  end
`else
  assign range_bad = 1'b0;
  assign err       = 1'b0;
`endif

  // State register and phase counter; counter only runs inside LOW/HIGH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if ((state == LOW || state == HIGH) && !last) cnt <= cnt + 4'd1;
      else                                          cnt <= '0;
    end
  end

  // Next state and SRAM strobes; purely from registers (plus req in IDLE) so
  // an asynchronous reset drops the strobes and releases DQ immediately.
  always_comb begin
    nxt       = state;
    ready     = 1'b0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = req_q.data[15:0];
    SRAM_ADDR = {req_q.word, 1'b0};
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) nxt = range_bad ? DONE : LOW;
      end
      LOW: begin
        SRAM_OE_N = req_q.store;
        // The last cycle releases WE with address/data still stable.
        SRAM_WE_N = ~req_q.store | last;
        dq_oe     = req_q.store;
        if (last) nxt = HIGH;
      end
      HIGH: begin
        SRAM_ADDR = {req_q.word, 1'b1};
        dq_out    = req_q.data[31:16];
        SRAM_OE_N = req_q.store;
        SRAM_WE_N = ~req_q.store | last;
        dq_oe     = req_q.store;
        if (last) nxt = DONE;
      end
      DONE: begin
        ready = 1'b1;
        nxt   = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign SRAM_DQ = dq_oe ? dq_out : 16'bz;

  // Latch the request on acceptance; capture load halves on the last cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q     <= '0;
      read_data <= '0;
    end else begin
      if (state == IDLE && req) begin
        req_q <= '{store: MEM_W_EN, word: word_d, data: ST_val};
        if (range_bad && !MEM_W_EN) read_data <= '0;
      end
      if (state == LOW && last && !req_q.store)  read_data[15:0]  <= SRAM_DQ;
      if (state == HIGH && last && !req_q.store) read_data[31:16] <= SRAM_DQ;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: main instance with WAIT_CYCLES=4 and a
// second instance with WAIT_CYCLES=1, each with a small async-SRAM model.
module tb_sram_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst;
  logic        r_en, w_en;
  logic [31:0] alu, st;
  logic [31:0] rd;
  logic        rdy, err;
  logic [17:0] sa;
  wire  [15:0] dq;
  logic        we_n, oe_n;
  logic        probe;
  logic [15:0] mem [64];

  sram_controller #(.ADDR_BASE(1024), .WAIT_CYCLES(4), .SRAM_AW(18)) u_dut (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en), .ALU_Res(alu),
    .ST_val(st), .read_data(rd), .ready(rdy), .err(err), .SRAM_ADDR(sa),
    .SRAM_DQ(dq), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n)
  );

  // SRAM model: drives on OE, captures while WE is low; probe drives a marker.
  assign dq = probe ? 16'h5A5A : (!oe_n ? mem[sa[5:0]] : 16'hzzzz);
  always @(posedge clk) if (!we_n) mem[sa[5:0]] <= dq;

  logic        r1, w1;
  logic [31:0] alu1, st1, rd1;
  logic        rdy1, err1;
  logic [17:0] sa1;
  wire  [15:0] dq1;
  logic        we1_n, oe1_n;
  logic        we1_fell;
  logic [15:0] mem1 [64];

  sram_controller #(.ADDR_BASE(1024), .WAIT_CYCLES(1), .SRAM_AW(18)) u_w1 (
    .clk(clk), .rst(rst), .MEM_R_EN(r1), .MEM_W_EN(w1), .ALU_Res(alu1),
    .ST_val(st1), .read_data(rd1), .ready(rdy1), .err(err1), .SRAM_ADDR(sa1),
    .SRAM_DQ(dq1), .SRAM_WE_N(we1_n), .SRAM_OE_N(oe1_n)
  );

  assign dq1 = !oe1_n ? mem1[sa1[5:0]] : 16'hzzzz;
  always @(posedge clk) if (!we1_n) mem1[sa1[5:0]] <= dq1;
  always @(negedge we1_n) we1_fell = 1'b1;

  logic        we_h [0:40];
  logic        oe_h [0:40];
  logic [17:0] sa_h [0:40];
  int          lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge, record strobes per cycle, and
  // return the number of ready=0 cycles before the ready pulse.
  task automatic xact(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic hold, output int l);
    @(negedge clk);
    r_en = r; w_en = w; alu = a; st = d; l = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      we_h[i] = we_n; oe_h[i] = oe_n; sa_h[i] = sa;
      if (rdy) break;
      l++;
      @(negedge clk);
    end
    if (!hold) begin r_en = 1'b0; w_en = 1'b0; end
  endtask

  initial begin
    rst = 1'b0; probe = 1'b0;
    r_en = 1'b0; w_en = 1'b0; alu = '0; st = '0;
    r1 = 1'b0; w1 = 1'b0; alu1 = '0; st1 = '0;
    we1_fell = 1'b0;
    for (int i = 0; i < 64; i++) begin mem[i] = '0; mem1[i] = '0; end

    // Reset state
    #2;
    chk("rst_ready", 32'(rdy), 32'd1);
    chk("rst_rdata", rd, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_we_n", 32'(we_n), 32'd1);
    chk("rst_oe_n", 32'(oe_n), 32'd1);
    chk("rst_addr", 32'(sa), 32'd0);
    @(negedge clk); rst = 1'b1;
    we1_fell = 1'b0;

    // Store 0xDEADBEEF at 1028 -> locations 2/3
    xact(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, lat);
    chk("st_latency", 32'(lat), 32'd9);
    chk("st_we_c0", 32'(we_h[0]), 32'd1);
    chk("st_we_c1", 32'(we_h[1]), 32'd0);
    chk("st_we_c4", 32'(we_h[4]), 32'd1);
    chk("st_we_c5", 32'(we_h[5]), 32'd0);
    chk("st_we_c8", 32'(we_h[8]), 32'd1);
    chk("st_oe_c2", 32'(oe_h[2]), 32'd1);
    chk("st_addr_c1", 32'(sa_h[1]), 32'd2);
    chk("st_addr_c4", 32'(sa_h[4]), 32'd2);
    chk("st_addr_c5", 32'(sa_h[5]), 32'd3);
    chk("st_addr_c8", 32'(sa_h[8]), 32'd3);
    chk("st_mem2", 32'(mem[2]), 32'h0000BEEF);
    chk("st_mem3", 32'(mem[3]), 32'h0000DEAD);
    chk("st_rdata_kept", rd, 32'h0);

    // Load it back
    xact(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, lat);
    chk("ld_latency", 32'(lat), 32'd9);
    chk("ld_rdata", rd, 32'hDEADBEEF);
    chk("ld_err", 32'(err), 32'd0);
    chk("ld_oe_c1", 32'(oe_h[1]), 32'd0);
    chk("ld_oe_c8", 32'(oe_h[8]), 32'd0);
    chk("ld_oe_done", 32'(oe_h[9]), 32'd1);
    chk("ld_we_c2", 32'(we_h[2]), 32'd1);

    // Both enables high -> store of 0x12345678 at 1024
    xact(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0, lat);
    chk("rw_latency", 32'(lat), 32'd9);
    chk("rw_mem0", 32'(mem[0]), 32'h00005678);
    chk("rw_mem1", 32'(mem[1]), 32'h00001234);
    chk("rw_rdata_kept", rd, 32'hDEADBEEF);

    // Back-to-back loads: request held through DONE
    xact(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, lat);
    chk("b2b_lat1", 32'(lat), 32'd9);
    chk("b2b_rdata1", rd, 32'hDEADBEEF);
    xact(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, lat);
    chk("b2b_lat2", 32'(lat), 32'd9);
    chk("b2b_rdata2", rd, 32'h12345678);

    // read_data persists while idle
    repeat (3) @(negedge clk);
    #1 chk("rdata_persist", rd, 32'h12345678);
    chk("idle_ready", 32'(rdy), 32'd1);

`ifdef SRAM_RANGE_CHECK_EN
    // Below base: straight to DONE with err
    xact(1'b1, 1'b0, 32'd0, 32'h0, 1'b0, lat);
    chk("rng_latency", 32'(lat), 32'd1);
    chk("rng_err", 32'(err), 32'd1);
    chk("rng_rdata", rd, 32'h0);
    chk("rng_oe_c0", 32'(oe_h[0]), 32'd1);
    chk("rng_oe_c1", 32'(oe_h[1]), 32'd1);
    @(negedge clk); #1;
    chk("rng_err_pulse", 32'(err), 32'd0);
`else
    // Below base wraps by truncation: word 0x1FF00 -> location 0x3FE00
    xact(1'b1, 1'b0, 32'd0, 32'h0, 1'b0, lat);
    chk("wrap_latency", 32'(lat), 32'd9);
    chk("wrap_addr", 32'(sa_h[1]), 32'h0003FE00);
    chk("wrap_addr_hi", 32'(sa_h[5]), 32'h0003FE01);
    chk("wrap_err", 32'(err), 32'd0);
    chk("wrap_rdata", rd, 32'h12345678);
`endif

    // WAIT_CYCLES=1: store completes with WE never asserted
    @(negedge clk);
    w1 = 1'b1; alu1 = 32'd1028; st1 = 32'hAAAA5555; lat = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (rdy1) break;
      lat++;
      @(negedge clk);
    end
    w1 = 1'b0;
    chk("w1_latency", 32'(lat), 32'd3);
    chk("w1_we_never_fell", 32'(we1_fell), 32'd0);
    chk("w1_mem_untouched", 32'(mem1[2]), 32'h0);

    // Reset in the middle of a store's LOW phase
    @(negedge clk);
    w_en = 1'b1; alu = 32'd1032; st = 32'hCAFEF00D;
    @(negedge clk); @(negedge clk); #1;
    chk("mid_we_low", 32'(we_n), 32'd0);
    rst = 1'b0; #1;
    chk("mid_rst_we_n", 32'(we_n), 32'd1);
    chk("mid_rst_oe_n", 32'(oe_n), 32'd1);
    probe = 1'b1; #1;
    chk("mid_rst_dq_released", 32'(dq), 32'h00005A5A);
    probe = 1'b0; w_en = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    chk("post_rst_ready", 32'(rdy), 32'd1);
    chk("post_rst_rdata", rd, 32'h0);
    @(negedge clk); #1;
    chk("post_rst_idle", 32'(rdy), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
